somador_serial_2bits: RTL



---
 rtl/somador_serial_2bits.sv | 104 ++++++++++
 1 files changed

// File: rtl/somador_serial_2bits.sv
// Serial adder controller: feeds an external 2-bit full-adder one digit per
// clock, LSB digit first, and assembles the WIDTH-bit sum and final carry.
module somador_serial_2bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [1:0]       add_a,
    output logic [1:0]       add_b,
    output logic             add_cin,
    input  logic [1:0]       add_s,
    input  logic             add_cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH+1:0] s_ext;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             run;
    logic             last;

    assign run   = (state_q == RUN);
    assign last  = (cnt_q == CW'(STEPS - 1));

    // New digit enters at the top so the LSB digit ends up at bit 0.
    assign s_ext = {add_s, s_q};
    assign s_d   = s_ext[WIDTH+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= add_cout;
                    a_q     <= a_q >> 2;
                    b_q     <= b_q >> 2;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a   = run ? a_q[1:0] : 2'b00;
    assign add_b   = run ? b_q[1:0] : 2'b00;
    assign add_cin = run ? carry_q : 1'b0;

    assign sum  = s_q;
    assign cout = carry_q;
    assign busy = run;
    assign done = (state_q == DONE);

endmodule
